// File: rtl/fp_add_result_pack.sv
// Final pack stage of the FP adder: builds the IEEE-754 word, forwards flags through a skid buffer.
// Optional sticky status/exception counter is enabled with `define FPU_STICKY_FLAGS_EN.
module fp_add_result_pack #(
    parameter logic [22:0] QNAN_MANT = 23'h400000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [22:0] in_mant,
    input  logic        invalid_flag,
    input  logic        overflow_flag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_invalid,
    output logic        out_overflow,
    input  logic        flags_clr,
    output logic        sticky_invalid,
    output logic        sticky_overflow,
    output logic [7:0]  exc_count
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned WORD_W = 1 + EXP_W + MANT_W;
    localparam int unsigned CNT_W  = 8;

    typedef struct packed {
        logic [WORD_W-1:0] result;
        logic              inv;
        logic              ovf;
    } beat_t;

    localparam beat_t BEAT_ZERO = '{result: '0, inv: 1'b0, ovf: 1'b0};

    beat_t r_main;
    beat_t r_skid;
    logic  r_main_valid;
    logic  r_skid_valid;
    logic  r_in_ready;

    beat_t w_in_beat;
    beat_t w_main_nxt;
    beat_t w_skid_nxt;
    logic  w_main_valid_nxt;
    logic  w_skid_valid_nxt;
    logic  w_in_xfer;
    logic  w_out_xfer;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_main_valid & out_ready;

    // Packing: invalid wins over overflow; both flags still travel with the word.
    always_comb begin
        w_in_beat.inv = invalid_flag;
        w_in_beat.ovf = overflow_flag;
        if (invalid_flag) begin
            w_in_beat.result = {1'b0, {EXP_W{1'b1}}, QNAN_MANT};
        end else if (overflow_flag) begin
            w_in_beat.result = {in_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else begin
            w_in_beat.result = {in_sign, in_exp, in_mant};
        end
    end

    // Main/skid steering; a full skid implies a full main and in_ready low.
    always_comb begin
        w_main_nxt       = r_main;
        w_skid_nxt       = r_skid;
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (r_skid_valid) begin
            if (out_ready) begin
                w_main_nxt       = r_skid;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (w_in_xfer) begin
            if (!r_main_valid || out_ready) begin
                w_main_nxt       = w_in_beat;
                w_main_valid_nxt = 1'b1;
            end else begin
                w_skid_nxt       = w_in_beat;
                w_skid_valid_nxt = 1'b1;
            end
        end else if (w_out_xfer) begin
            w_main_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main       <= BEAT_ZERO;
            r_skid       <= BEAT_ZERO;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_main_valid;
    assign out_result   = r_main.result;
    assign out_invalid  = r_main.inv;
    assign out_overflow = r_main.ovf;

`ifdef FPU_STICKY_FLAGS_EN
    logic             r_sticky_inv;
    logic             r_sticky_ovf;
    logic [CNT_W-1:0] r_exc_count;
    logic             w_xfer_inv;
    logic             w_xfer_ovf;
    logic             w_xfer_flagged;

    assign w_xfer_inv     = w_out_xfer & r_main.inv;
    assign w_xfer_ovf     = w_out_xfer & r_main.ovf;
    assign w_xfer_flagged = w_xfer_inv | w_xfer_ovf;

    // Status follows delivered beats; a clear coinciding with a flagged delivery keeps the new event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky_inv <= 1'b0;
            r_sticky_ovf <= 1'b0;
            r_exc_count  <= '0;
        end else if (flags_clr) begin
            r_sticky_inv <= w_xfer_inv;
            r_sticky_ovf <= w_xfer_ovf;
            r_exc_count  <= CNT_W'(w_xfer_flagged);
        end else begin
            r_sticky_inv <= r_sticky_inv | w_xfer_inv;
            r_sticky_ovf <= r_sticky_ovf | w_xfer_ovf;
            if (w_xfer_flagged && (r_exc_count != {CNT_W{1'b1}})) begin
                r_exc_count <= r_exc_count + CNT_W'(1);
            end
        end
    end

    assign sticky_invalid  = r_sticky_inv;
    assign sticky_overflow = r_sticky_ovf;
    assign exc_count       = r_exc_count;
`else
    logic w_unused_flags_clr;

    assign w_unused_flags_clr = flags_clr;
    assign sticky_invalid     = 1'b0;
    assign sticky_overflow    = 1'b0;
    assign exc_count          = '0;
`endif

endmodule

// File: tb/tb_fp_add_result_pack.sv
// Directed bench for fp_add_result_pack: packing, skid ordering, sticky status, reset.
module tb_fp_add_result_pack;

`ifdef FPU_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_mant;
    logic        invalid_flag;
    logic        overflow_flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_invalid;
    logic        out_overflow;
    logic        flags_clr;
    logic        sticky_invalid;
    logic        sticky_overflow;
    logic [7:0]  exc_count;

    int n_checks = 0;
    int n_fail   = 0;

    fp_add_result_pack dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_mant        (in_mant),
        .invalid_flag   (invalid_flag),
        .overflow_flag  (overflow_flag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_invalid    (out_invalid),
        .out_overflow   (out_overflow),
        .flags_clr      (flags_clr),
        .sticky_invalid (sticky_invalid),
        .sticky_overflow(sticky_overflow),
        .exc_count      (exc_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [22:0] m,
                         input logic inv, input logic ovf);
        in_valid      = v;
        in_sign       = s;
        in_exp        = e;
        in_mant       = m;
        invalid_flag  = inv;
        overflow_flag = ovf;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result: got %h want 0", out_result); end
        n_checks++; if (exc_count !== 8'h0) begin n_fail++; $display("FAIL reset_exc_count: got %h want 0", exc_count); end
        n_checks++; if ({sticky_invalid, sticky_overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_sticky: got %b%b want 00", sticky_invalid, sticky_overflow); end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_normal;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h7F, 23'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL normal_valid: got %b want 1", out_valid); end
        n_checks++; if (out_result !== 32'h3F800000) begin n_fail++; $display("FAIL normal_result: got %h want 3f800000", out_result); end
        n_checks++; if ({out_invalid, out_overflow} !== 2'b00) begin n_fail++; $display("FAIL normal_flags: got %b%b want 00", out_invalid, out_overflow); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL normal_drained: got %b want 0", out_valid); end
        n_checks++; if ({sticky_invalid, sticky_overflow, exc_count} !== 10'h0) begin n_fail++; $display("FAIL normal_no_sticky: got %b%b %h want 00 00", sticky_invalid, sticky_overflow, exc_count); end
    endtask

    task automatic test_stream;
        logic        s [3]  = '{1'b1, 1'b0, 1'b0};
        logic [7:0]  e [3]  = '{8'h7F, 8'h00, 8'hFE};
        logic [22:0] m [3]  = '{23'h0, 23'h1, 23'h7FFFFF};
        logic [31:0] w [3]  = '{32'hBF800000, 32'h00000001, 32'h7F7FFFFF};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                n_checks++; if (out_valid !== 1'b1 || out_result !== w[i-1]) begin n_fail++; $display("FAIL stream_beat%0d: got v=%b %h want v=1 %h", i - 1, out_valid, out_result, w[i-1]); end
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready%0d: got %b want 1", i - 1, in_ready); end
            end
            if (i < 3) drive(1'b1, s[i], e[i], m[i], 1'b0, 1'b0);
            else       drive(1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0);
            @(negedge clk);
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_priority;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 8'h12, 23'h5, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0);
        n_checks++; if (out_result !== 32'h7FC00000) begin n_fail++; $display("FAIL prio_result: got %h want 7fc00000", out_result); end
        n_checks++; if ({out_invalid, out_overflow} !== 2'b11) begin n_fail++; $display("FAIL prio_flags: got %b%b want 11", out_invalid, out_overflow); end
        @(negedge clk);
        n_checks++; if ({sticky_invalid, sticky_overflow} !== {STICKY, STICKY}) begin n_fail++; $display("FAIL prio_sticky: got %b%b want %b%b", sticky_invalid, sticky_overflow, STICKY, STICKY); end
        n_checks++; if (exc_count !== (STICKY ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL prio_count: got %0d want %0d", exc_count, STICKY ? 1 : 0); end
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        n_checks++; if ({sticky_invalid, sticky_overflow, exc_count} !== 10'h0) begin n_fail++; $display("FAIL clr_plain: got %b%b %h want 00 00", sticky_invalid, sticky_overflow, exc_count); end
    endtask

    task automatic test_overflow;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 8'h40, 23'h1234, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++; if (out_result !== 32'hFF800000 || {out_invalid, out_overflow} !== 2'b01) begin n_fail++; $display("FAIL ovf_first: got %h %b%b want ff800000 01", out_result, out_invalid, out_overflow); end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || out_result !== 32'hFF800000) begin n_fail++; $display("FAIL ovf_second: got v=%b %h want v=1 ff800000", out_valid, out_result); end
        @(negedge clk);
        n_checks++; if ({sticky_invalid, sticky_overflow} !== {1'b0, STICKY}) begin n_fail++; $display("FAIL ovf_sticky: got %b%b want 0%b", sticky_invalid, sticky_overflow, STICKY); end
        n_checks++; if (exc_count !== (STICKY ? 8'd2 : 8'd0)) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", exc_count, STICKY ? 2 : 0); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h80, 23'h123456, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || out_result !== 32'h40123456) begin n_fail++; $display("FAIL b2b_c1: got rdy=%b %h want rdy=1 40123456", in_ready, out_result); end
        drive(1'b1, 1'b1, 8'h81, 23'h1, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0 || out_result !== 32'h40123456) begin n_fail++; $display("FAIL b2b_c2: got rdy=%b %h want rdy=0 40123456", in_ready, out_result); end
        drive(1'b1, 1'b0, 8'h01, 23'h0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h40123456) begin n_fail++; $display("FAIL b2b_c3: got rdy=%b v=%b %h want rdy=0 v=1 40123456", in_ready, out_valid, out_result); end
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_result !== 32'hC0800001) begin n_fail++; $display("FAIL b2b_second: got v=%b %h want v=1 c0800001", out_valid, out_result); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back: got %b want 1", in_ready); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
        n_checks++; if (exc_count !== (STICKY ? 8'd2 : 8'd0)) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", exc_count, STICKY ? 2 : 0); end
    endtask

    task automatic test_clr_collision;
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h03, 23'h7, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0);
        n_checks++; if (out_result !== 32'h7FC00000) begin n_fail++; $display("FAIL clr_held: got %h want 7fc00000", out_result); end
        flags_clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        n_checks++; if ({sticky_invalid, sticky_overflow} !== {STICKY, 1'b0}) begin n_fail++; $display("FAIL clr_collide_sticky: got %b%b want %b0", sticky_invalid, sticky_overflow, STICKY); end
        n_checks++; if (exc_count !== (STICKY ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL clr_collide_count: got %0d want %0d", exc_count, STICKY ? 1 : 0); end
    endtask

    task automatic stream_ovf(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 8'h10, 23'h0, 1'b0, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_saturation;
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        stream_ovf(254);
        n_checks++; if (exc_count !== (STICKY ? 8'hFE : 8'h00)) begin n_fail++; $display("FAIL sat_254: got %h want %h", exc_count, STICKY ? 8'hFE : 8'h00); end
        stream_ovf(1);
        n_checks++; if (exc_count !== (STICKY ? 8'hFF : 8'h00)) begin n_fail++; $display("FAIL sat_255: got %h want %h", exc_count, STICKY ? 8'hFF : 8'h00); end
        stream_ovf(45);
        n_checks++; if (exc_count !== (STICKY ? 8'hFF : 8'h00)) begin n_fail++; $display("FAIL sat_300: got %h want %h", exc_count, STICKY ? 8'hFF : 8'h00); end
    endtask

    task automatic test_reset_skid;
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 8'h00, 23'h0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h20, 23'h0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0);
        n_checks++; if (in_ready !== 1'b0 || out_invalid !== 1'b1) begin n_fail++; $display("FAIL rskid_full: got rdy=%b inv=%b want rdy=0 inv=1", in_ready, out_invalid); end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || {out_invalid, out_overflow} !== 2'b00) begin n_fail++; $display("FAIL rskid_out: got v=%b %h %b%b want v=0 0 00", out_valid, out_result, out_invalid, out_overflow); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rskid_in_ready_low: got %b want 0", in_ready); end
        n_checks++; if ({sticky_invalid, sticky_overflow, exc_count} !== 10'h0) begin n_fail++; $display("FAIL rskid_status: got %b%b %h want 00 00", sticky_invalid, sticky_overflow, exc_count); end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rskid_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rskid_no_ghost: got %b want 0", out_valid); end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        flags_clr = 1'b0;
        drive(1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_normal();
        test_stream();
        test_priority();
        test_overflow();
        test_back_to_back();
        test_clr_collision();
        test_saturation();
        test_reset_skid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_add_result_pack.md
FP_ADD_RESULT_PACK -- requirements
Module: fp_add_result_pack

Interface
REQ-001 Parameter: QNAN_MANT, 23'h400000, mantissa field of the canonical quiet NaN.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream result beat valid.
REQ-005 in_ready  output  1  stage can accept a beat.
REQ-006 in_sign  input  1  rounded sum sign.
REQ-007 in_exp  input  8  rounded sum biased exponent.
REQ-008 in_mant  input  23  rounded sum fraction.
REQ-009 invalid_flag  input  1  invalid flag of the same beat, from exception detection.
REQ-010 overflow_flag  input  1  overflow flag of the same beat, from exception detection.
REQ-011 out_valid  output  1  packed result valid.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_result  output  32  IEEE-754 single {sign, exp, mant}.
REQ-014 out_invalid  output  1  invalid flag travelling with out_result.
REQ-015 out_overflow  output  1  overflow flag travelling with out_result.
REQ-016 flags_clr  input  1  clear the sticky status.
REQ-017 sticky_invalid  output  1  accumulated invalid status.
REQ-018 sticky_overflow  output  1  accumulated overflow status.
REQ-019 exc_count  output  8  saturating count of flagged transfers.

Function
REQ-020 Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-021 Packing: invalid_flag=1 -> {1'b0, 8'hFF, QNAN_MANT}; else overflow_flag=1 -> {in_sign, 8'hFF, 23'h0}; else {in_sign, in_exp, in_mant}.
REQ-022 invalid_flag has priority over overflow_flag when both are 1; both flags are still forwarded unchanged on out_invalid/out_overflow.
REQ-023 Storage: one output register (main) plus one skid register; out_* driven only from main.
REQ-024 Latency: exactly 1 cycle from input transfer to out_valid when main is empty or draining.
REQ-025 in_ready = ~skid_valid, registered, with no combinational path from out_ready.
REQ-026 Input transfer while main is empty, or main is full and out_ready=1 -> packed beat loads main.
REQ-027 Input transfer while main is full and out_ready=0 -> packed beat loads skid; in_ready drops next cycle.
REQ-028 Skid full and out_ready=1 -> skid moves to main and skid empties; in_ready=1 next cycle.
REQ-029 Beats leave in arrival order; no beat is dropped or duplicated; out_* stay stable while out_valid=1 and out_ready=0.
REQ-030 Sticky state sets on an output transfer carrying the corresponding flag, not on input transfer.
REQ-031 flags_clr=1 with no flagged output transfer in the same cycle -> sticky bits and exc_count go to 0 next cycle.
REQ-032 flags_clr=1 with a flagged output transfer in the same cycle -> sticky bits reload from that beat's flags and exc_count=1 (new event wins).
REQ-033 exc_count increments by 1 per output transfer with out_invalid|out_overflow, and saturates at 8'hFF.

Reset
REQ-034 rst_n=0 at a clock edge -> main/skid valid=0, out_result=0, out_invalid=0, out_overflow=0, sticky_*=0, exc_count=0.
REQ-035 in_ready=0 while rst_n=0, and 1 in the first cycle after release.
REQ-036 Reset mid-operation discards both held beats with no output transfer; the data is lost by design.

Configuration
REQ-037 Macro FPU_STICKY_FLAGS_EN defined -> REQ-030..REQ-033 are implemented.
REQ-038 FPU_STICKY_FLAGS_EN undefined -> sticky_invalid, sticky_overflow and exc_count are tied to 0, flags_clr is ignored, and no status registers exist; the datapath is unchanged.

Verification
REQ-039 Normal beat {0, 8'h7F, 23'h0}, both flags 0, out_ready=1 -> next cycle out_result=32'h3F800000, out_valid=1, no sticky change.
REQ-040 Both invalid_flag=1 and overflow_flag=1, in_sign=1 -> out_result=32'h7FC00000, out_invalid=1, out_overflow=1.
REQ-041 overflow_flag=1 only, in_sign=1 -> out_result=32'hFF800000, sticky_overflow=1 after the transfer.
REQ-042 out_ready=0 for 3 cycles with continuous in_valid -> 2 beats accepted, in_ready=0 from cycle 2; after out_ready=1, both beats emerge in order.
REQ-043 flags_clr=1 in the same cycle as an invalid output transfer -> sticky_invalid=1, exc_count=1.
REQ-044 300 overflow transfers -> exc_count=8'hFF; rst_n=0 during a stalled skid -> all outputs 0 next cycle, in_ready=1 after release.
